// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - register file read/write/issue bus with master/slave views
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic                issue_en;
  logic [AW-1:0]       issue_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_en, issue_addr, flush,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_en, issue_addr, flush,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - integer register file with dual writeback, bypass and busy scoreboard
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  localparam logic [AW-1:0] R0 = '0;

  logic [XLEN-1:0]     mem [NREG];
  logic [NREG-1:0]     busy;
  logic [NREG-1:0]     busy_nxt;
  logic [NREG-1:0]     clr;
  logic [AW:0]         cnt_nxt;
  logic [AW:0]         cnt_q;
  logic [AW-1:0]       ra [NRD];
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rb;
  logic                wr0_ok;
  logic                wr1_ok;

  // r0 swallows writes when it is hardwired to zero
  assign wr0_ok = bus.we0 && !(ZERO_REG != 0 && bus.waddr0 == R0);
  assign wr1_ok = bus.we1 && !(ZERO_REG != 0 && bus.waddr1 == R0);

  // storage update; WB1 is applied last so it wins an address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      if (wr0_ok) mem[bus.waddr0] <= bus.wdata0;
      if (wr1_ok) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  // registers being written back this cycle lose their busy mark
  always_comb begin
    clr = '0;
    for (int i = 0; i < NREG; i++)
      clr[i] = (bus.we0 && bus.waddr0 == AW'(i)) || (bus.we1 && bus.waddr1 == AW'(i));
  end

  // next busy vector: flush beats issue, issue (new producer) beats writeback clear
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (bus.issue_en && bus.issue_addr == AW'(i) && !(ZERO_REG != 0 && i == 0))
          busy_nxt[i] = 1'b1;
        else if (clr[i])
          busy_nxt[i] = 1'b0;
      end
    end
  end

  // population count of the next busy vector
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
  end

  // scoreboard state and registered busy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // split the packed read address bus into per-port addresses
  always_comb begin
    for (int k = 0; k < NRD; k++) ra[k] = bus.raddr[k*AW +: AW];
  end

  // combinational read ports with optional same-cycle forwarding; forced to 0 in reset
  always_comb begin
    rd = '0;
    rb = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!rst && !(ZERO_REG != 0 && ra[k] == R0)) begin
        if (BYPASS != 0 && bus.we1 && bus.waddr1 == ra[k])
          rd[k*XLEN +: XLEN] = bus.wdata1;
        else if (BYPASS != 0 && bus.we0 && bus.waddr0 == ra[k])
          rd[k*XLEN +: XLEN] = bus.wdata0;
        else
          rd[k*XLEN +: XLEN] = mem[ra[k]];
        rb[k] = busy[ra[k]] & ~clr[ra[k]];
      end
    end
  end

  assign bus.rdata    = rd;
  assign bus.rbusy    = rb;
  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) ia ();
  reg_file_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) ib ();
  reg_file_sb_if #(.XLEN(64), .NREG(16), .NRD(4)) ic ();

  reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  reg_file_sb #(.XLEN(64), .NREG(16), .NRD(4), .ZERO_REG(1), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  iad;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic        e_rb0;
    logic [31:0] e_rd1;
    logic        e_rb1;
    logic [5:0]  e_cnt;
    logic [31:0] e_brd0;
  } vec_t;

  vec_t tbl [18];

  // reference model state for the wide build
  logic [63:0] mem_m  [16];
  logic        busy_m [16];
  logic        r_we0, r_we1, r_iss, r_fl;
  logic [3:0]  r_wa0, r_wa1, r_iad;
  logic [63:0] r_wd0, r_wd1;
  logic [3:0]  r_ra [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic iss, input logic [4:0] iad, input logic fl,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] e_rd0, input logic e_rb0,
                              input logic [31:0] e_rd1, input logic e_rb1,
                              input logic [5:0] e_cnt, input logic [31:0] e_brd0);
    vec_t v;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.iss = iss; v.iad = iad; v.fl = fl;
    v.ra0 = ra0; v.ra1 = ra1;
    v.e_rd0 = e_rd0; v.e_rb0 = e_rb0; v.e_rd1 = e_rd1; v.e_rb1 = e_rb1;
    v.e_cnt = e_cnt; v.e_brd0 = e_brd0;
    return v;
  endfunction

  task automatic drive_ab(input vec_t v);
    ia.we0 = v.we0; ia.waddr0 = v.wa0; ia.wdata0 = v.wd0;
    ia.we1 = v.we1; ia.waddr1 = v.wa1; ia.wdata1 = v.wd1;
    ia.issue_en = v.iss; ia.issue_addr = v.iad; ia.flush = v.fl;
    ia.raddr = {v.ra1, v.ra0};
    ib.we0 = v.we0; ib.waddr0 = v.wa0; ib.wdata0 = v.wd0;
    ib.we1 = v.we1; ib.waddr1 = v.wa1; ib.wdata1 = v.wd1;
    ib.issue_en = v.iss; ib.issue_addr = v.iad; ib.flush = v.fl;
    ib.raddr = {v.ra1, v.ra0};
  endtask

  task automatic idle_c();
    ic.we0 = 1'b0; ic.waddr0 = '0; ic.wdata0 = '0;
    ic.we1 = 1'b0; ic.waddr1 = '0; ic.wdata1 = '0;
    ic.issue_en = 1'b0; ic.issue_addr = '0; ic.flush = 1'b0;
    ic.raddr = '0;
  endtask

  function automatic logic [63:0] model_read(input logic [3:0] a);
    if (a == 4'd0) return 64'd0;
    if (r_we1 && r_wa1 == a) return r_wd1;
    if (r_we0 && r_wa0 == a) return r_wd0;
    return mem_m[a];
  endfunction

  function automatic logic model_busy(input logic [3:0] a);
    if (a == 4'd0) return 1'b0;
    if ((r_we0 && r_wa0 == a) || (r_we1 && r_wa1 == a)) return 1'b0;
    return busy_m[a];
  endfunction

  initial begin : main
    vec_t idle_v;
    int   n;

    // expected behaviour of the 32x32 builds, one record per cycle
    //            we0 wa0 wd0          we1 wa1 wd1          iss iad fl ra0 ra1 e_rd0        rb0 e_rd1        rb1 cnt b_rd0
    tbl[0]  = mk(1, 3, 32'h11,       1, 3, 32'h22,       0, 0, 0, 3, 0,  32'h22,      0, 32'h0,       0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 3, 3,  32'h22,      0, 32'h22,      0, 0, 32'h22);
    tbl[2]  = mk(1, 0, 32'hFFFF,     0, 0, 32'h0,        1, 0, 0, 0, 0,  32'h0,       0, 32'h0,       0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 3,  32'h0,       0, 32'h22,      0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 7, 0, 7, 3,  32'h0,       0, 32'h22,      0, 1, 32'h0);
    tbl[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 7, 0,  32'h0,       1, 32'h0,       0, 1, 32'h0);
    tbl[6]  = mk(0, 0, 32'h0,        1, 7, 32'h77,       0, 0, 0, 7, 7,  32'h77,      0, 32'h77,      0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 7, 0,  32'h77,      0, 32'h0,       0, 0, 32'h77);
    tbl[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 0, 9, 0,  32'h0,       0, 32'h0,       0, 1, 32'h0);
    tbl[9]  = mk(1, 9, 32'h99,       0, 0, 32'h0,        1, 9, 0, 9, 0,  32'h99,      0, 32'h0,       0, 1, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 9, 0,  32'h99,      1, 32'h0,       0, 1, 32'h99);
    tbl[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 0, 2, 0,  32'h0,       0, 32'h0,       0, 2, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 0, 2, 9,  32'h0,       1, 32'h99,      1, 3, 32'h0);
    tbl[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 6, 0, 4, 6,  32'h0,       1, 32'h0,       0, 4, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 8, 1, 6, 9,  32'h0,       1, 32'h99,      1, 0, 32'h0);
    tbl[15] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 8, 6,  32'h0,       0, 32'h0,       0, 0, 32'h0);
    tbl[16] = mk(1, 12, 32'hABC,     1, 31, 32'h3131,    0, 0, 0, 12, 31, 32'hABC,    0, 32'h3131,    0, 0, 32'h0);
    tbl[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 12, 31, 32'hABC,    0, 32'h3131,    0, 0, 32'hABC);

    idle_v = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    drive_ab(idle_v);
    idle_c();

    // reset state while rst is held
    #12;
    chk("reset_a_rdata", {32'h0, ia.rdata}, 64'h0);
    chk("reset_a_rbusy", {62'h0, ia.rbusy}, 64'h0);
    chk("reset_a_cnt", {58'h0, ia.busy_cnt}, 64'h0);
    chk("reset_c_rdata_lo", ic.rdata[63:0], 64'h0);
    chk("reset_c_cnt", {59'h0, ic.busy_cnt}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // reset pulse mid-run clears written data and busy state
    ia.we0 = 1'b1; ia.waddr0 = 5'd5; ia.wdata0 = 32'hDEADBEEF;
    ia.issue_en = 1'b1; ia.issue_addr = 5'd10;
    @(posedge clk); #1;
    drive_ab(idle_v);
    ia.raddr = {5'd10, 5'd5};
    #1;
    chk("pre_rst_rdata0", {32'h0, ia.rdata[31:0]}, 64'hDEADBEEF);
    chk("pre_rst_rbusy", {62'h0, ia.rbusy}, 64'h2);
    chk("pre_rst_cnt", {58'h0, ia.busy_cnt}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("in_rst_rdata", {32'h0, ia.rdata}, 64'h0);
    chk("in_rst_rbusy", {62'h0, ia.rbusy}, 64'h0);
    chk("in_rst_cnt", {58'h0, ia.busy_cnt}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rdata0", {32'h0, ia.rdata[31:0]}, 64'h0);
    chk("post_rst_rbusy", {62'h0, ia.rbusy}, 64'h0);
    chk("post_rst_cnt", {58'h0, ia.busy_cnt}, 64'h0);

    // directed table on the bypass and non-bypass builds
    for (int i = 0; i < 18; i++) begin
      drive_ab(tbl[i]);
      @(negedge clk);
      chk($sformatf("t%0d_a_rd0", i), {32'h0, ia.rdata[31:0]}, {32'h0, tbl[i].e_rd0});
      chk($sformatf("t%0d_a_rb0", i), {63'h0, ia.rbusy[0]}, {63'h0, tbl[i].e_rb0});
      chk($sformatf("t%0d_a_rd1", i), {32'h0, ia.rdata[63:32]}, {32'h0, tbl[i].e_rd1});
      chk($sformatf("t%0d_a_rb1", i), {63'h0, ia.rbusy[1]}, {63'h0, tbl[i].e_rb1});
      chk($sformatf("t%0d_b_rd0", i), {32'h0, ib.rdata[31:0]}, {32'h0, tbl[i].e_brd0});
      @(posedge clk); #1;
      chk($sformatf("t%0d_a_cnt", i), {58'h0, ia.busy_cnt}, {58'h0, tbl[i].e_cnt});
      chk($sformatf("t%0d_b_cnt", i), {58'h0, ib.busy_cnt}, {58'h0, tbl[i].e_cnt});
    end
    drive_ab(idle_v);

    // random traffic on the 4-port 64-bit 16-entry build against the model
    for (int i = 0; i < 16; i++) begin
      mem_m[i]  = 64'h0;
      busy_m[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r_we0 = 1'($urandom_range(0, 1));
      r_wa0 = 4'($urandom_range(0, 15));
      r_wd0 = {$urandom, $urandom};
      r_we1 = 1'($urandom_range(0, 1));
      r_wa1 = ($urandom_range(0, 3) == 0) ? r_wa0 : 4'($urandom_range(0, 15));
      r_wd1 = {$urandom, $urandom};
      r_iss = 1'($urandom_range(0, 1));
      r_iad = ($urandom_range(0, 5) == 0) ? r_wa0 : 4'($urandom_range(0, 15));
      r_fl  = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 4; k++)
        r_ra[k] = ($urandom_range(0, 3) == 0) ? r_wa1 : 4'($urandom_range(0, 15));
      ic.we0 = r_we0; ic.waddr0 = r_wa0; ic.wdata0 = r_wd0;
      ic.we1 = r_we1; ic.waddr1 = r_wa1; ic.wdata1 = r_wd1;
      ic.issue_en = r_iss; ic.issue_addr = r_iad; ic.flush = r_fl;
      for (int k = 0; k < 4; k++) ic.raddr[k*4 +: 4] = r_ra[k];
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk("rand_rdata", ic.rdata[k*64 +: 64], model_read(r_ra[k]));
        chk("rand_rbusy", {63'h0, ic.rbusy[k]}, {63'h0, model_busy(r_ra[k])});
      end
      @(posedge clk); #1;
      if (r_we0 && r_wa0 != 4'd0) mem_m[r_wa0] = r_wd0;
      if (r_we1 && r_wa1 != 4'd0) mem_m[r_wa1] = r_wd1;
      if (r_fl) begin
        for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
      end else begin
        if (r_we0) busy_m[r_wa0] = 1'b0;
        if (r_we1) busy_m[r_wa1] = 1'b0;
        if (r_iss && r_iad != 4'd0) busy_m[r_iad] = 1'b1;
      end
      n = 0;
      for (int i = 0; i < 16; i++) n += busy_m[i] ? 1 : 0;
      chk("rand_cnt", {59'h0, ic.busy_cnt}, 64'(n));
    end
    idle_c();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
